// File: rtl/shot_resolver.sv
// -----------------------------------------------------------------------------
// shot_resolver
//   Turn controller in front of the two ship-position boards. Accepts one shot
//   (cell index + shooter), drives the target board's lookup address, waits for
//   the board's registered ship code and reports MISS / HIT / REPEAT / INVALID.
//   Tracks per-player shot history and hit counts, and flags game_over/winner
//   once a player has hit SHIP_CELLS ship cells.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   new_game                        clear history/counters/game_over, abort shot
//   shot_valid, shot_ready          shot handshake
//   shot_xy[6:0], shooter           target cell (row*10+col), 0 host / 1 guest
//   ship_xy_host/guest[6:0]         registered lookup address to each board
//   ship_code_host/guest[1:0]       board code, one cycle after the address
//   result_valid, result[1:0]       one-cycle result pulse, result class
//   result_code[1:0]                ship code on a HIT, else 00
//   hits_host/guest[6:0]            hits scored by each shooter
//   game_over, winner               sticky end-of-game flag and winning side
// -----------------------------------------------------------------------------
module shot_resolver #(
  parameter int SHIP_CELLS = 17,
  parameter int CELLS      = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       shot_valid,
  input  logic [6:0] shot_xy,
  input  logic       shooter,
  output logic       shot_ready,
  output logic [6:0] ship_xy_host,
  output logic [6:0] ship_xy_guest,
  input  logic [1:0] ship_code_host,
  input  logic [1:0] ship_code_guest,
  output logic       result_valid,
  output logic [1:0] result,
  output logic [1:0] result_code,
  output logic [6:0] hits_host,
  output logic [6:0] hits_guest,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_FETCH, S_RESULT} state_e;
  typedef enum logic [1:0] {
    RES_MISS    = 2'b00,
    RES_HIT     = 2'b01,
    RES_REPEAT  = 2'b10,
    RES_INVALID = 2'b11
  } res_e;

  localparam logic [6:0] WIN_HITS = 7'(SHIP_CELLS);
  localparam logic [6:0] CELL_LIM = 7'(CELLS);

  state_e                 state_q, state_d;
  logic [6:0]             xy_q, xy_d;
  logic                   who_q, who_d;
  res_e                   res_q, res_d;
  logic [1:0]             code_q, code_d;
  logic [6:0]             addr_host_q, addr_host_d;
  logic [6:0]             addr_guest_q, addr_guest_d;
  logic [1:0][CELLS-1:0]  hist_q, hist_d;     // [shooter][cell]
  logic [1:0][6:0]        hits_q, hits_d;     // [shooter]
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             result_q, result_d;
  logic [1:0]             rcode_q, rcode_d;
  logic                   over_q, over_d;
  logic                   winner_q, winner_d;

  logic       accept;
  logic [1:0] tgt_code;

  // shot_ready is decoded straight from state, so it reads 1 while in reset.
  assign shot_ready = (state_q == S_IDLE) && !over_q;
  // new_game has priority over a same-cycle shot.
  assign accept     = shot_valid && shot_ready && !new_game;
  // Shooter 0 fires at the guest board, shooter 1 at the host board.
  assign tgt_code   = who_q ? ship_code_host : ship_code_guest;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    xy_d         = xy_q;
    who_d        = who_q;
    res_d        = res_q;
    code_d       = code_q;
    addr_host_d  = addr_host_q;
    addr_guest_d = addr_guest_q;
    hist_d       = hist_q;
    hits_d       = hits_q;
    rvalid_d     = 1'b0;
    result_d     = result_q;
    rcode_d      = rcode_q;
    over_d       = over_q;
    winner_d     = winner_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          xy_d    = shot_xy;
          who_d   = shooter;
          code_d  = 2'b00;
          state_d = S_RESULT;
          if (shot_xy >= CELL_LIM) begin
            res_d = RES_INVALID;
          end else if (hist_q[shooter][shot_xy]) begin
            res_d = RES_REPEAT;
          end else begin
            // Only the target board's address moves.
            if (shooter) addr_host_d  = shot_xy;
            else         addr_guest_d = shot_xy;
            state_d = S_ADDR;
          end
        end
      end
      // The board registers the address at the end of this cycle.
      S_ADDR: state_d = S_FETCH;
      S_FETCH: begin
        hist_d[who_q][xy_q] = 1'b1;
        if (tgt_code != 2'b00) begin
          res_d  = RES_HIT;
          code_d = tgt_code;
          if (hits_q[who_q] < WIN_HITS) hits_d[who_q] = hits_q[who_q] + 7'd1;
        end else begin
          res_d  = RES_MISS;
          code_d = 2'b00;
        end
        state_d = S_RESULT;
      end
      S_RESULT: begin
        rvalid_d = 1'b1;
        result_d = res_q;
        rcode_d  = code_q;
        // The counter was bumped in FETCH; the win is published with the result.
        if (res_q == RES_HIT && hits_q[who_q] == WIN_HITS) begin
          over_d   = 1'b1;
          winner_d = who_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort whatever is in flight; board addresses deliberately keep their value.
    if (new_game) begin
      state_d  = S_IDLE;
      hist_d   = '0;
      hits_d   = '0;
      rvalid_d = 1'b0;
      over_d   = 1'b0;
      winner_d = 1'b0;
    end
  end

  // NOTE: the history maps are plain flops and must read clear straight out of
  // reset, so they sit in the reset branch like every other register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      xy_q         <= '0;
      who_q        <= 1'b0;
      res_q        <= RES_MISS;
      code_q       <= '0;
      addr_host_q  <= '0;
      addr_guest_q <= '0;
      hist_q       <= '0;
      hits_q       <= '0;
      rvalid_q     <= 1'b0;
      result_q     <= '0;
      rcode_q      <= '0;
      over_q       <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      xy_q         <= xy_d;
      who_q        <= who_d;
      res_q        <= res_d;
      code_q       <= code_d;
      addr_host_q  <= addr_host_d;
      addr_guest_q <= addr_guest_d;
      hist_q       <= hist_d;
      hits_q       <= hits_d;
      rvalid_q     <= rvalid_d;
      result_q     <= result_d;
      rcode_q      <= rcode_d;
      over_q       <= over_d;
      winner_q     <= winner_d;
    end
  end

  assign ship_xy_host  = addr_host_q;
  assign ship_xy_guest = addr_guest_q;
  assign result_valid  = rvalid_q;
  assign result        = result_q;
  assign result_code   = rcode_q;
  assign hits_host     = hits_q[0];
  assign hits_guest    = hits_q[1];
  assign game_over     = over_q;
  assign winner        = winner_q;

endmodule
